// File: rtl/aud_session_ctrl.sv
// Session controller for the WM8731 record/playback path.
// Synchronises keys and block status, sequences INIT/IDLE/REC/PLAY/PAUSE
// per SRAM slot, keeps the per-slot stop offsets and muxes the SRAM bus.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | codec I2C initialisation running, waiting for i2c_done level
// IDLE  | waiting for a record or play command
// REC   | recorder writing into act_slot
// PLAY  | DSP reading act_slot up to its stop offset
// PAUSE | DSP held mid-playback on act_slot
module aud_session_ctrl #(
    parameter int  ADDR_W  = 20,
    parameter int  DATA_W  = 16,
    parameter int  N_SLOTS = 4,
    parameter int  TIME_W  = 5,
    localparam int SLOT_W  = $clog2(N_SLOTS),
    localparam int OFF_W   = ADDR_W - SLOT_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_key_rec,
    input  logic                i_key_play,
    input  logic                i_key_stop,
    input  logic [SLOT_W-1:0]   i_slot_sel,
    input  logic                i_i2c_done,
    input  logic                i_rec_done,
    input  logic                i_play_done,
    input  logic [OFF_W-1:0]    i_rec_off,
    input  logic [DATA_W-1:0]   i_rec_data,
    input  logic [OFF_W-1:0]    i_play_off,
    output logic                o_i2c_en,
    output logic                o_rec_en,
    output logic                o_play_en,
    output logic                o_play_pause,
    output logic [OFF_W-1:0]    o_play_stop_off,
    output logic [ADDR_W-1:0]   o_sram_addr,
    output logic [DATA_W-1:0]   o_sram_dq,
    output logic                o_sram_dq_oe,
    output logic                o_sram_we_n,
    output logic [2:0]          o_state,
    output logic [N_SLOTS-1:0]  o_slot_valid,
    output logic [TIME_W-1:0]   o_time
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_REC   = 3'd2,
        ST_PLAY  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    // Bit positions inside the edge-detected group.
    localparam int IX_REC   = 0;
    localparam int IX_PLAY  = 1;
    localparam int IX_STOP  = 2;
    localparam int IX_RDONE = 3;
    localparam int IX_PDONE = 4;

    logic [5:0] async_in;
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;
    logic [4:0] sync3_q;
    logic [4:0] pulse;
    logic       i2c_lvl;

    state_t                 state_q, state_d;
    logic [SLOT_W-1:0]      act_slot_q, act_slot_d;
    logic [N_SLOTS-1:0]     valid_q, valid_d;
    logic [OFF_W-1:0]       stop_tbl_q [N_SLOTS];
    logic                   tbl_we;
    logic                   rec_full;

    logic                   i2c_en_q;
    logic                   rec_en_q;
    logic                   play_en_q;
    logic                   pause_q;

    logic [ADDR_W-1:0]      sram_addr;
    logic [DATA_W-1:0]      sram_dq;
    logic                   sram_oe;
    logic                   sram_we_n;
    logic [TIME_W-1:0]      time_v;

    // i2c_done sits on bit 5 and is only used as a level, so it skips the third stage.
    assign async_in = {i_i2c_done, i_play_done, i_rec_done, i_key_stop, i_key_play, i_key_rec};

    // Two-flop synchroniser for all async inputs plus one delay stage for edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q[4:0];
        end
    end

    assign pulse    = sync2_q[4:0] & ~sync3_q;
    assign i2c_lvl  = sync2_q[5];
    assign rec_full = &i_rec_off;

    // Next-state logic; stop outranks everything, so in IDLE a coincident stop swallows rec/play.
    always_comb begin
        state_d    = state_q;
        act_slot_d = act_slot_q;
        valid_d    = valid_q;
        tbl_we     = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (i2c_lvl) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!pulse[IX_STOP]) begin
                    if (pulse[IX_REC]) begin
                        state_d             = ST_REC;
                        act_slot_d          = i_slot_sel;
                        valid_d[i_slot_sel] = 1'b0;
                    end else if (pulse[IX_PLAY] && valid_q[i_slot_sel]) begin
                        state_d    = ST_PLAY;
                        act_slot_d = i_slot_sel;
                    end
                end
            end
            ST_REC: begin
                if (pulse[IX_STOP] || pulse[IX_RDONE] || rec_full) begin
                    state_d             = ST_IDLE;
                    tbl_we              = 1'b1;
                    valid_d[act_slot_q] = 1'b1;
                end
            end
            ST_PLAY: begin
                if (pulse[IX_STOP] || pulse[IX_PDONE]) state_d = ST_IDLE;
                else if (pulse[IX_PLAY])               state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pulse[IX_STOP])      state_d = ST_IDLE;
                else if (pulse[IX_PLAY]) state_d = ST_PLAY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, active slot, slot-valid bits and stop-offset table.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_INIT;
            act_slot_q <= '0;
            valid_q    <= '0;
            for (int k = 0; k < N_SLOTS; k++) stop_tbl_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            act_slot_q <= act_slot_d;
            valid_q    <= valid_d;
            if (tbl_we) stop_tbl_q[act_slot_q] <= i_rec_off;
        end
    end

    // Block enables are registered copies of the state, one cycle behind it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            i2c_en_q  <= 1'b1;
            rec_en_q  <= 1'b0;
            play_en_q <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            i2c_en_q  <= (state_q == ST_INIT);
            rec_en_q  <= (state_q == ST_REC);
            play_en_q <= (state_q == ST_PLAY) || (state_q == ST_PAUSE);
            pause_q   <= (state_q == ST_PAUSE);
        end
    end

    // SRAM bus and time display follow the current state and the live offsets.
    always_comb begin
        sram_addr = '0;
        sram_dq   = '0;
        sram_oe   = 1'b0;
        sram_we_n = 1'b1;
        time_v    = '0;
        case (state_q)
            ST_REC: begin
                sram_addr = {act_slot_q, i_rec_off};
                sram_dq   = i_rec_data;
                sram_oe   = 1'b1;
                sram_we_n = 1'b0;
                time_v    = i_rec_off[OFF_W-1 -: TIME_W];
            end
            ST_PLAY, ST_PAUSE: begin
                sram_addr = {act_slot_q, i_play_off};
                time_v    = i_play_off[OFF_W-1 -: TIME_W];
            end
            default: ;
        endcase
    end

    assign o_i2c_en        = i2c_en_q;
    assign o_rec_en        = rec_en_q;
    assign o_play_en       = play_en_q;
    assign o_play_pause    = pause_q;
    assign o_play_stop_off = stop_tbl_q[act_slot_q];
    assign o_sram_addr     = sram_addr;
    assign o_sram_dq       = sram_dq;
    assign o_sram_dq_oe    = sram_oe;
    assign o_sram_we_n     = sram_we_n;
    assign o_state         = state_q;
    assign o_slot_valid    = valid_q;
    assign o_time          = time_v;

endmodule

// File: tb/tb_aud_session_ctrl.sv
// Bench for aud_session_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_aud_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_rec, key_play, key_stop;
    logic [1:0]  slot_sel;
    logic        i2c_done, rec_done, play_done;
    logic [17:0] rec_off, play_off;
    logic [15:0] rec_data;

    logic        i2c_en, rec_en, play_en, play_pause;
    logic [17:0] stop_off;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq;
    logic        sram_oe, sram_we_n;
    logic [2:0]  state;
    logic [3:0]  slot_valid;
    logic [4:0]  time_o;

    // Eight-slot instance used for the address split check.
    logic        rst8_n, rec8, i2c8;
    logic [2:0]  sel8;
    logic [16:0] off8;
    logic        z8_en0, z8_en1, z8_en2, z8_en3, z8_oe, z8_we;
    logic [16:0] z8_stop;
    logic [19:0] addr8;
    logic [15:0] z8_dq;
    logic [2:0]  state8;
    logic [7:0]  z8_valid;
    logic [4:0]  z8_time;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model of the controller, expressed as histories and plain state numbers.
    int          m_state;
    logic [1:0]  m_act;
    logic [17:0] m_tbl [4];
    logic [3:0]  m_valid;
    logic        m_i2c_en, m_rec_en, m_play_en, m_pause;
    logic [2:0]  h_rec, h_play, h_stop, h_i2c, h_rd, h_pd;

    logic [19:0] e_addr;
    logic        e_we_n, e_oe;
    logic [4:0]  e_time;

    aud_session_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
        .i_slot_sel(slot_sel), .i_i2c_done(i2c_done), .i_rec_done(rec_done),
        .i_play_done(play_done), .i_rec_off(rec_off), .i_rec_data(rec_data),
        .i_play_off(play_off),
        .o_i2c_en(i2c_en), .o_rec_en(rec_en), .o_play_en(play_en),
        .o_play_pause(play_pause), .o_play_stop_off(stop_off),
        .o_sram_addr(sram_addr), .o_sram_dq(sram_dq), .o_sram_dq_oe(sram_oe),
        .o_sram_we_n(sram_we_n), .o_state(state), .o_slot_valid(slot_valid),
        .o_time(time_o)
    );

    aud_session_ctrl #(.N_SLOTS(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst8_n),
        .i_key_rec(rec8), .i_key_play(1'b0), .i_key_stop(1'b0),
        .i_slot_sel(sel8), .i_i2c_done(i2c8), .i_rec_done(1'b0),
        .i_play_done(1'b0), .i_rec_off(off8), .i_rec_data(16'h0),
        .i_play_off(17'h0),
        .o_i2c_en(z8_en0), .o_rec_en(z8_en1), .o_play_en(z8_en2),
        .o_play_pause(z8_en3), .o_play_stop_off(z8_stop),
        .o_sram_addr(addr8), .o_sram_dq(z8_dq), .o_sram_dq_oe(z8_oe),
        .o_sram_we_n(z8_we), .o_state(state8), .o_slot_valid(z8_valid),
        .o_time(z8_time)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_act    = '0;
        m_valid  = '0;
        for (int k = 0; k < 4; k++) m_tbl[k] = '0;
        m_i2c_en = 1'b1;
        m_rec_en = 1'b0;
        m_play_en = 1'b0;
        m_pause  = 1'b0;
        h_rec = '0; h_play = '0; h_stop = '0; h_i2c = '0; h_rd = '0; h_pd = '0;
    endtask

    // One clock edge of the spec: an input is seen as a pulse two edges after
    // it was first sampled high, and the i2c level with the same two-edge lag.
    task automatic model_step();
        bit p_rec, p_play, p_stop, p_rd, p_pd, lvl;
        int old;
        p_rec  = h_rec[1]  && !h_rec[2];
        p_play = h_play[1] && !h_play[2];
        p_stop = h_stop[1] && !h_stop[2];
        p_rd   = h_rd[1]   && !h_rd[2];
        p_pd   = h_pd[1]   && !h_pd[2];
        lvl    = h_i2c[1];
        old    = m_state;
        case (old)
            0: if (lvl) m_state = 1;
            1: if (!p_stop) begin
                   if (p_rec) begin
                       m_state = 2; m_act = slot_sel; m_valid[slot_sel] = 1'b0;
                   end else if (p_play && m_valid[slot_sel]) begin
                       m_state = 3; m_act = slot_sel;
                   end
               end
            2: if (p_stop || p_rd || rec_off == 18'h3FFFF) begin
                   m_tbl[m_act] = rec_off; m_valid[m_act] = 1'b1; m_state = 1;
               end
            3: if (p_stop || p_pd) m_state = 1; else if (p_play) m_state = 4;
            4: if (p_stop) m_state = 1; else if (p_play) m_state = 3;
            default: m_state = 1;
        endcase
        m_i2c_en  = (old == 0);
        m_rec_en  = (old == 2);
        m_play_en = (old == 3) || (old == 4);
        m_pause   = (old == 4);
        h_rec  = {h_rec[1:0],  key_rec};
        h_play = {h_play[1:0], key_play};
        h_stop = {h_stop[1:0], key_stop};
        h_i2c  = {h_i2c[1:0],  i2c_done};
        h_rd   = {h_rd[1:0],   rec_done};
        h_pd   = {h_pd[1:0],   play_done};
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) model_step();
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            e_addr = 20'h0; e_we_n = 1'b1; e_oe = 1'b0; e_time = 5'h0;
            if (m_state == 2) begin
                e_addr = {m_act, rec_off}; e_we_n = 1'b0; e_oe = 1'b1; e_time = rec_off[17:13];
            end else if (m_state == 3 || m_state == 4) begin
                e_addr = {m_act, play_off}; e_time = play_off[17:13];
            end
            chk("state", 64'(state), 64'(m_state));
            chk("i2c_en", 64'(i2c_en), 64'(m_i2c_en));
            chk("rec_en", 64'(rec_en), 64'(m_rec_en));
            chk("play_en", 64'(play_en), 64'(m_play_en));
            chk("pause", 64'(play_pause), 64'(m_pause));
            chk("slot_valid", 64'(slot_valid), 64'(m_valid));
            chk("stop_off", 64'(stop_off), 64'(m_tbl[m_act]));
            chk("sram_addr", 64'(sram_addr), 64'(e_addr));
            chk("we_n", 64'(sram_we_n), 64'(e_we_n));
            chk("dq_oe", 64'(sram_oe), 64'(e_oe));
            chk("time", 64'(time_o), 64'(e_time));
            if (e_oe) chk("sram_dq", 64'(sram_dq), 64'(rec_data));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        key_rec = 0; key_play = 0; key_stop = 0; slot_sel = 0;
        i2c_done = 0; rec_done = 0; play_done = 0;
        rec_off = 0; play_off = 0; rec_data = 0;
        rst8_n = 0; rec8 = 0; i2c8 = 0; sel8 = 0; off8 = 0;
        do_reset();
        #1 chk_en = 1'b1;
        cyc(2);
        rst_n = 1'b1;

        // T1: held in INIT until the i2c level propagates.
        cyc(10);
        chk("t1_init_state", 64'(state), 64'd0);
        chk("t1_init_i2c_en", 64'(i2c_en), 64'd1);
        i2c_done = 1;
        cyc(4);
        chk("t1_idle_state", 64'(state), 64'd1);
        chk("t1_i2c_en_low", 64'(i2c_en), 64'd0);

        // T2: record into slot 2 up to offset 0x1234, stop.
        slot_sel = 2; key_rec = 1;
        cyc(4);
        key_rec = 0;
        for (int k = 0; k <= 4; k++) begin
            rec_off = 18'h1230 + 18'(k); rec_data = 16'($urandom);
            cyc(1);
        end
        chk("t2_rec_addr", 64'(sram_addr), 64'h81234);
        chk("t2_rec_we_n", 64'(sram_we_n), 64'd0);
        chk("t2_rec_oe", 64'(sram_oe), 64'd1);
        key_stop = 1;
        cyc(4);
        key_stop = 0; rec_off = 18'h00777;
        cyc(3);
        chk("t2_idle", 64'(state), 64'd1);
        chk("t2_valid", 64'(slot_valid), 64'h4);
        chk("t2_stop_off", 64'(stop_off), 64'h1234);

        // T3: play, pause, resume, play_done.
        play_off = 18'h00200; key_play = 1;
        cyc(5);
        chk("t3_play_state", 64'(state), 64'd3);
        chk("t3_play_en", 64'(play_en), 64'd1);
        chk("t3_stop_off", 64'(stop_off), 64'h1234);
        key_play = 0; cyc(3);
        key_play = 1; cyc(5);
        chk("t3_pause_state", 64'(state), 64'd4);
        chk("t3_pause_out", 64'(play_pause), 64'd1);
        key_play = 0; cyc(3);
        key_play = 1; cyc(4);
        chk("t3_resume", 64'(state), 64'd3);
        key_play = 0; cyc(3);
        play_done = 1; cyc(4);
        chk("t3_done_idle", 64'(state), 64'd1);
        play_done = 0; cyc(3);

        // T4: play on an empty slot is ignored.
        slot_sel = 1; key_play = 1; cyc(5);
        chk("t4_state", 64'(state), 64'd1);
        chk("t4_play_en", 64'(play_en), 64'd0);
        key_play = 0; cyc(3);

        // T5: offset saturation ends the recording.
        slot_sel = 3; key_rec = 1; cyc(4);
        key_rec = 0; rec_off = 18'h00100; cyc(2);
        chk("t5_in_rec", 64'(state), 64'd2);
        rec_off = 18'h3FFFF; cyc(1);
        rec_off = 18'h0; cyc(2);
        chk("t5_auto_idle", 64'(state), 64'd1);
        chk("t5_valid", 64'(slot_valid), 64'hC);
        chk("t5_stop_off", 64'(stop_off), 64'h3FFFF);

        // Coincident stop and rec, first in REC, then in IDLE.
        slot_sel = 0; rec_off = 18'h00055; key_rec = 1; cyc(4);
        key_rec = 0; cyc(3);
        key_rec = 1; key_stop = 1; cyc(4);
        chk("t5_stop_wins_rec", 64'(state), 64'd1);
        key_rec = 0; key_stop = 0; cyc(3);
        key_rec = 1; key_stop = 1; cyc(4);
        chk("t5_stop_wins_idle", 64'(state), 64'd1);
        key_rec = 0; key_stop = 0; cyc(3);

        // T6: reset in the middle of a recording.
        slot_sel = 1; key_rec = 1; cyc(4);
        key_rec = 0; cyc(2);
        do_reset();
        #1;
        chk("t6_state", 64'(state), 64'd0);
        chk("t6_i2c_en", 64'(i2c_en), 64'd1);
        chk("t6_rec_en", 64'(rec_en), 64'd0);
        chk("t6_valid", 64'(slot_valid), 64'd0);
        chk("t6_we_n", 64'(sram_we_n), 64'd1);
        cyc(2);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) key_rec  = ~key_rec;
            if ($urandom_range(0, 5) == 0) key_play = ~key_play;
            if ($urandom_range(0, 9) == 0) key_stop = ~key_stop;
            if ($urandom_range(0, 19) == 0) rec_done  = ~rec_done;
            if ($urandom_range(0, 19) == 0) play_done = ~play_done;
            if ($urandom_range(0, 7) == 0) i2c_done = ~i2c_done;
            slot_sel = 2'($urandom_range(0, 3));
            rec_off  = ($urandom_range(0, 39) == 0) ? 18'h3FFFF : 18'($urandom);
            play_off = 18'($urandom);
            rec_data = 16'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
                cyc(1);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        chk_en = 1'b0;

        // Eight slots: slot index occupies the top three address bits.
        rst8_n = 1'b1; i2c8 = 1;
        cyc(4);
        sel8 = 3'd5; rec8 = 1;
        cyc(4);
        off8 = 17'h1ABCD;
        #1;
        chk("t6_n8_state", 64'(state8), 64'd2);
        chk("t6_n8_addr", 64'(addr8), 64'hBABCD);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
